iiitb_sipo: RTL and testbench
=============================

Name: iiitb_sipo

Overview:
- Serial-in parallel-out deserializer; the receive-side neighbour of the team's PISO serializer.
- Captures a serial stream, LSB first, framed by a one-cycle start strobe, into a WIDTH-bit word.
- Presents each word on a valid/ready parallel interface to downstream logic, with overrun detection.
- Optional even/odd parity bit check.

Parameters:
- WIDTH, 8, data word width in bits (valid range 2..32).
- ODD_PARITY, 0, parity sense when SIPO_PARITY_EN is defined: 0 = even, 1 = odd; ignored otherwise.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-low reset
- sin_start  input  1  frame strobe; high in the same cycle as data bit 0
- data_in  input  1  serial data, LSB first, one bit per clk
- out_ready  input  1  downstream accepts word when high with out_valid
- data_out  output  WIDTH  assembled word (holding register)
- out_valid  output  1  data_out holds an unconsumed word
- busy  output  1  frame capture in progress
- overrun  output  1  one-cycle pulse: completed word dropped because holding register full
- parity_err  output  1  sticky-per-word flag qualified by out_valid; constant 0 without macro

Behaviour:
- Reset (rst low, asynchronous): state IDLE; shift register, bit counter, data_out all 0; out_valid, busy, overrun, parity_err all 0. Reset mid-frame discards partial word and any held word.
- States: IDLE, SHIFT, PAR (PAR exists only with SIPO_PARITY_EN).
- IDLE: sin_start=1 -> sample data_in into bit 0, count=1, go SHIFT, busy=1 from next cycle. data_in ignored without sin_start.
- SHIFT: each cycle samples data_in into bit position count (LSB first), count++. After bit WIDTH-1 is sampled: without parity go IDLE and commit; with parity go PAR.
- PAR: sample parity bit; commit; go IDLE.
- Commit (registered, visible next edge): bit-0 sample at cycle 0 gives out_valid high at cycle WIDTH (WIDTH+1 with parity).
  - If out_valid=0, or out_valid=1 and out_ready=1 in the commit cycle: load data_out, set out_valid=1, update parity_err.
  - If out_valid=1 and out_ready=0: drop the new word, data_out unchanged, overrun=1 for exactly one cycle.
- Handshake: word transfers on any edge with out_valid=1 and out_ready=1; out_valid clears next cycle unless a commit occurs in that same cycle (then stays 1 with the new word). data_out stable while out_valid=1 and out_ready=0.
- sin_start during SHIFT/PAR: abort current partial word (no commit, no overrun), restart with data_in as the new bit 0, count=1.
- busy: high in SHIFT and PAR, low in IDLE. Back-to-back frames allowed: sin_start in the cycle after the last bit is accepted from IDLE.
- Counter width: clog2(WIDTH)+1 bits; no wrap beyond WIDTH.

Optional Feature:
- Macro SIPO_PARITY_EN.
- Defined: one parity bit follows the data bit WIDTH-1 (PAR state). parity_err = (XOR of the WIDTH data bits XOR parity bit) != ODD_PARITY. It is loaded with data_out and is valid while out_valid=1.
- Undefined: no PAR state, frame is WIDTH bits, parity_err tied 0.

Test Plan:
- WIDTH=8, out_ready=1: sin_start with bits 1,0,1,0,0,1,0,1 on cycles 0-7 -> out_valid=1 at cycle 8, data_out=0xA5, busy high cycles 1-7.
- Two back-to-back frames 0x3C then 0xC3 with out_ready=0 -> first held as 0x3C, overrun pulses one cycle at second commit, data_out stays 0x3C. Then out_ready=1 -> out_valid drops next cycle.
- Held 0x11, send 0x22 with out_ready asserted exactly in the commit cycle -> out_valid stays 1, data_out=0x22, no overrun.
- sin_start re-asserted after 4 bits of a frame, then 8 bits of 0x5A -> single word 0x5A, no overrun, partial word discarded.
- rst pulled low at bit 5 of a frame while holding 0x77 -> all outputs 0 immediately; next full frame 0xF0 received correctly.
- SIPO_PARITY_EN, ODD_PARITY=0: 0xA5 with parity bit 0 -> parity_err=0, valid at cycle 9; same data with parity bit 1 -> parity_err=1.

Source files
------------

// File: rtl/iiitb_sipo_if.sv
// Parallel/serial bus between the SIPO deserializer and its neighbours.
// Latency: none (wires only). Backpressure: out_ready qualifies out_valid.
// The serial source and parallel sink act as master; the deserializer is the slave.
interface iiitb_sipo_if #(
    parameter int WIDTH = 8
);
    logic             sin_start;
    logic             data_in;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             busy;
    logic             overrun;
    logic             parity_err;

    modport master (
        output sin_start, data_in, out_ready,
        input  data_out, out_valid, busy, overrun, parity_err
    );

    modport slave (
        input  sin_start, data_in, out_ready,
        output data_out, out_valid, busy, overrun, parity_err
    );
endinterface

// File: rtl/iiitb_sipo.sv
// Serial-in parallel-out deserializer, LSB first, framed by a start strobe.
// Latency: word visible WIDTH cycles after bit 0 (WIDTH+1 with SIPO_PARITY_EN).
// Backpressure: one holding register; a completed word is dropped with an overrun pulse when it is full.
module iiitb_sipo #(
    parameter int WIDTH      = 8,
    parameter int ODD_PARITY = 0
) (
    input logic        clk,
    input logic        rst,
    iiitb_sipo_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int IW = CW - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
`ifdef SIPO_PARITY_EN
        ,PAR  = 2'd2
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             commit;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             ovr_q;
`ifdef SIPO_PARITY_EN
    logic             word_perr;
    logic             perr_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    // A start strobe always wins: it restarts capture from any state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        commit  = 1'b0;
        word    = shreg_q;
`ifdef SIPO_PARITY_EN
        word_perr = 1'b0;
`endif
        if (bus.sin_start) begin
            state_d = SHIFT;
            cnt_d   = CW'(1);
            shreg_d = WIDTH'(bus.data_in);
        end else begin
            case (state_q)
                IDLE: ;
                SHIFT: begin
                    shreg_d[cnt_q[IW-1:0]] = bus.data_in;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
                        state_d = PAR;
`else
                        state_d = IDLE;
                        cnt_d   = '0;
                        commit  = 1'b1;
                        word    = shreg_d;
`endif
                    end
                end
`ifdef SIPO_PARITY_EN
                PAR: begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    commit    = 1'b1;
                    word      = shreg_q;
                    word_perr = ((^shreg_q) ^ bus.data_in) != (ODD_PARITY != 0);
                end
`endif
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Commit and handshake share one register so a same-cycle drain and refill keeps out_valid high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            ovr_q <= 1'b0;
            if (commit && (!valid_q || bus.out_ready)) begin
                data_q  <= word;
                valid_q <= 1'b1;
`ifdef SIPO_PARITY_EN
                perr_q  <= word_perr;
`endif
            end else if (commit) begin
                ovr_q <= 1'b1;
            end else if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.data_out  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.overrun   = ovr_q;
`ifdef SIPO_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    logic unused_odd_parity;
    assign unused_odd_parity = (ODD_PARITY != 0);
    assign bus.parity_err    = 1'b0;
`endif
endmodule

// File: tb/tb_iiitb_sipo.sv
// Bench for iiitb_sipo: directed table, hand-written corner sequences, and random traffic
// compared against a queue-based frame model.
module tb_iiitb_sipo;
    localparam int W   = 8;
    localparam int ODD = 0;
`ifdef SIPO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    iiitb_sipo_if #(.WIDTH(W)) bus ();

    iiitb_sipo #(.WIDTH(W), .ODD_PARITY(ODD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: bits of the current frame in a queue, one holding slot.
    int           mq[$];
    bit           m_active;
    bit           m_valid;
    bit           m_ovr;
    bit           m_perr;
    logic [W-1:0] m_data;
    bit           mcheck;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_active = 0;
        m_valid  = 0;
        m_ovr    = 0;
        m_perr   = 0;
        m_data   = '0;
    endtask

    task automatic model_step(input bit s, input bit d, input bit r);
        bit           done;
        bit           pe;
        int           ones;
        logic [W-1:0] w;
        done = 0;
        pe   = 0;
        w    = '0;
        if (s) begin
            mq.delete();
            mq.push_back(int'(d));
            m_active = 1;
        end else if (m_active) begin
            mq.push_back(int'(d));
        end
        if (m_active && mq.size() == FL) begin
            done     = 1;
            m_active = 0;
            ones     = 0;
            for (int i = 0; i < W; i++) begin
                if (mq[i] != 0) w[i] = 1'b1;
            end
            for (int i = 0; i < FL; i++) ones += mq[i];
`ifdef SIPO_PARITY_EN
            pe = ((ones % 2) != ODD);
`endif
        end
        m_ovr = 0;
        if (done) begin
            if (!m_valid || r) begin
                m_data  = w;
                m_valid = 1;
                m_perr  = pe;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && r) begin
            m_valid = 0;
        end
    endtask

    task automatic step(input bit s, input bit d, input bit r);
        bus.sin_start = s;
        bus.data_in   = d;
        bus.out_ready = r;
        @(posedge clk);
        model_step(s, d, r);
        @(negedge clk);
        if (mcheck) begin
            chk("valid",      32'(bus.out_valid),  32'(m_valid));
            chk("data",       32'(bus.data_out),   32'(m_data));
            chk("busy",       32'(bus.busy),       32'(m_active));
            chk("overrun",    32'(bus.overrun),    32'(m_ovr));
            chk("parity_err", 32'(bus.parity_err), 32'(m_perr));
        end
    endtask

    task automatic send_frame(input logic [W-1:0] w, input bit pbit, input bit r_last, input bit r_other);
        for (int i = 0; i < FL; i++) begin
            step(i == 0, (i < W) ? w[i] : pbit, (i == FL - 1) ? r_last : r_other);
        end
    endtask

    typedef struct {
        bit           s;
        bit           d;
        bit           r;
        bit           ev;
        logic [7:0]   edat;
        bit           eb;
        bit           eo;
    } vec_t;
    vec_t tbl[9];

    initial begin
        // 0xA5 LSB first with out_ready held high; expectations are the state after each edge.
        tbl[0] = '{1, 1, 1, 0, 8'h00, 1, 0};
        tbl[1] = '{0, 0, 1, 0, 8'h00, 1, 0};
        tbl[2] = '{0, 1, 1, 0, 8'h00, 1, 0};
        tbl[3] = '{0, 0, 1, 0, 8'h00, 1, 0};
        tbl[4] = '{0, 0, 1, 0, 8'h00, 1, 0};
        tbl[5] = '{0, 1, 1, 0, 8'h00, 1, 0};
        tbl[6] = '{0, 0, 1, 0, 8'h00, 1, 0};
        tbl[7] = '{0, 1, 1, 1, 8'hA5, 0, 0};
        tbl[8] = '{0, 0, 1, 0, 8'hA5, 0, 0};

        bus.sin_start = 0;
        bus.data_in   = 0;
        bus.out_ready = 0;
        model_reset();
        mcheck = 1;

        #3;
        chk("rst_valid",   32'(bus.out_valid),  32'd0);
        chk("rst_data",    32'(bus.data_out),   32'd0);
        chk("rst_busy",    32'(bus.busy),       32'd0);
        chk("rst_overrun", 32'(bus.overrun),    32'd0);
        chk("rst_perr",    32'(bus.parity_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;

`ifndef SIPO_PARITY_EN
        mcheck = 0;
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].s, tbl[i].d, tbl[i].r);
            chk($sformatf("tbl%0d_valid", i),   32'(bus.out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_data", i),    32'(bus.data_out),  32'(tbl[i].edat));
            chk($sformatf("tbl%0d_busy", i),    32'(bus.busy),      32'(tbl[i].eb));
            chk($sformatf("tbl%0d_overrun", i), 32'(bus.overrun),   32'(tbl[i].eo));
        end
        mcheck = 1;
`endif

        // Back-to-back frames into a full holding register.
        send_frame(8'h3C, 0, 0, 0);
        chk("b2b_first_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b_first_data",  32'(bus.data_out),  32'h3C);
        send_frame(8'hC3, 0, 0, 0);
        chk("b2b_overrun",     32'(bus.overrun),   32'd1);
        chk("b2b_data_kept",   32'(bus.data_out),  32'h3C);
        step(0, 0, 0);
        chk("b2b_overrun_end", 32'(bus.overrun),   32'd0);
        step(0, 0, 1);
        chk("b2b_drain",       32'(bus.out_valid), 32'd0);

        // Drain and refill on the same edge.
        send_frame(8'h11, 0, 0, 0);
        send_frame(8'h22, 0, 1, 0);
        chk("refill_valid",   32'(bus.out_valid), 32'd1);
        chk("refill_data",    32'(bus.data_out),  32'h22);
        chk("refill_overrun", 32'(bus.overrun),   32'd0);
        step(0, 0, 1);

        // Restart after four bits of an abandoned frame.
        step(1, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1);
        send_frame(8'h5A, 0, 1, 1);
        chk("abort_valid",   32'(bus.out_valid), 32'd1);
        chk("abort_data",    32'(bus.data_out),  32'h5A);
        chk("abort_overrun", 32'(bus.overrun),   32'd0);
        step(0, 0, 1);

        // Asynchronous reset mid-frame while a word is held.
        send_frame(8'h77, 0, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        bus.data_in = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid),  32'd0);
        chk("arst_data",  32'(bus.data_out),   32'd0);
        chk("arst_busy",  32'(bus.busy),       32'd0);
        chk("arst_ovr",   32'(bus.overrun),    32'd0);
        chk("arst_perr",  32'(bus.parity_err), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        send_frame(8'hF0, 0, 0, 0);
        chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("post_rst_data",  32'(bus.data_out),  32'hF0);
        step(0, 0, 1);

`ifdef SIPO_PARITY_EN
        send_frame(8'hA5, 0, 1, 1);
        chk("par_good_valid", 32'(bus.out_valid),  32'd1);
        chk("par_good_perr",  32'(bus.parity_err), 32'd0);
        step(0, 0, 1);
        send_frame(8'hA5, 1, 1, 1);
        chk("par_bad_valid",  32'(bus.out_valid),  32'd1);
        chk("par_bad_perr",   32'(bus.parity_err), 32'd1);
        step(0, 0, 1);
`endif

        // Random traffic: sparse starts cause aborts, overruns and idle gaps.
        for (int n = 0; n < 800; n++) begin
            step($urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
